// File: rtl/hilo_md_unit.sv
// HI/LO register pair with an iterative restoring divider and multiply-accumulate path.
// Define HILO_BYPASS_EN to make hi_o/lo_o show the value about to be committed.
module hilo_md_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid_i,
    input  logic [2:0]          op_i,
    input  logic [DATA_W-1:0]   rs_i,
    input  logic [DATA_W-1:0]   rt_i,
    input  logic [2*DATA_W-1:0] prod_i,
    input  logic                cancel_i,
    output logic                busy_o,
    output logic                div_done_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o
);
    // state  | meaning
    // S_IDLE | HI/LO ops accepted, no divide pending
    // S_RUN  | one restoring quotient bit per cycle, DATA_W cycles
    // S_FIX  | sign correction and HI/LO commit (held one extra cycle on divide by zero)
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MTHI   = 3'b001;
    localparam logic [2:0] OP_MTLO   = 3'b010;
    localparam logic [2:0] OP_WRPROD = 3'b011;
    localparam logic [2:0] OP_MADD   = 3'b100;
    localparam logic [2:0] OP_MSUB   = 3'b101;
    localparam logic [2:0] OP_DIV    = 3'b110;
    localparam logic [2:0] OP_DIVU   = 3'b111;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [DATA_W-1:0]   quo, rem, dvd, dsr_mag;
    logic                neg_q, neg_r, div0;
    logic                div_done_q;

    logic                acc, commit, is_div;
    logic [DATA_W-1:0]   a_mag, b_mag, q_fix, r_fix;
    logic [DATA_W-1:0]   hi_nxt, lo_nxt;
    logic [2*DATA_W-1:0] hilo, madd_sum, msub_diff;
    logic [DATA_W:0]     rem_sh, trial;

    assign acc    = op_valid_i && (state == S_IDLE) && !cancel_i;
    assign is_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign commit = (state == S_FIX) && (cnt == '0) && !cancel_i;

    assign a_mag = (op_i == OP_DIV && rs_i[DATA_W-1]) ? -rs_i : rs_i;
    assign b_mag = (op_i == OP_DIV && rt_i[DATA_W-1]) ? -rt_i : rt_i;

    assign rem_sh = {rem, quo[DATA_W-1]};
    assign trial  = rem_sh - {1'b0, dsr_mag};

    assign q_fix = div0 ? '1  : (neg_q ? -quo : quo);
    assign r_fix = div0 ? dvd : (neg_r ? -rem : rem);

    assign hilo      = {hi_q, lo_q};
    assign madd_sum  = hilo + prod_i;
    assign msub_diff = hilo - prod_i;

    always_comb begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        if (commit) begin
            hi_nxt = r_fix;
            lo_nxt = q_fix;
        end else if (acc) begin
            case (op_i)
                OP_MTHI:   hi_nxt = rs_i;
                OP_MTLO:   lo_nxt = rs_i;
                OP_WRPROD: {hi_nxt, lo_nxt} = prod_i;
                OP_MADD:   {hi_nxt, lo_nxt} = madd_sum;
                OP_MSUB:   {hi_nxt, lo_nxt} = msub_diff;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            quo        <= '0;
            rem        <= '0;
            dvd        <= '0;
            dsr_mag    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div0       <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            hi_q       <= hi_nxt;
            lo_q       <= lo_nxt;
            div_done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc && is_div) begin
                        dvd     <= rs_i;
                        dsr_mag <= b_mag;
                        quo     <= a_mag;
                        rem     <= '0;
                        neg_q   <= (op_i == OP_DIV) && (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]);
                        neg_r   <= (op_i == OP_DIV) && rs_i[DATA_W-1];
                        div0    <= (rt_i == '0);
                        // Divide by zero bypasses RUN but still spends two cycles busy.
                        if (rt_i == '0) begin
                            state <= S_FIX;
                            cnt   <= CNT_ONE;
                        end else begin
                            state <= S_RUN;
                            cnt   <= CNT_LAST;
                        end
                    end
                end
                S_RUN: begin
                    if (cancel_i) begin
                        state <= S_IDLE;
                    end else begin
                        if (!trial[DATA_W]) begin
                            rem <= trial[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b1};
                        end else begin
                            rem <= rem_sh[DATA_W-1:0];
                            quo <= {quo[DATA_W-2:0], 1'b0};
                        end
                        if (cnt == '0) state <= S_FIX;
                        else           cnt   <= cnt - CNT_ONE;
                    end
                end
                S_FIX: begin
                    if (cancel_i) begin
                        state <= S_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state      <= S_IDLE;
                        div_done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = (state != S_IDLE);
    assign div_done_o = div_done_q;

`ifdef HILO_BYPASS_EN
    assign hi_o = hi_nxt;
    assign lo_o = lo_nxt;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule
